// File: rtl/vx_commit_arb_pkg.sv
// Shared types and sizing for the commit/writeback stage.
//   commit_src_e  : index of each commit source on the source lanes
//   commit_data_t : one writeback packet as carried from a source to the register file
package vx_commit_arb_pkg;

    localparam int NUM_SRCS    = 5;
    localparam int NUM_THREADS = 4;
    localparam int NUM_WARPS   = 4;
    localparam int NW_BITS     = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
    localparam int XLEN        = 32;
    localparam int NR_BITS     = 6;
    localparam int UUID_WIDTH  = 44;
    // Up to NUM_SRCS sources plus the store path can retire in one cycle.
    localparam int CNT_W       = $clog2(NUM_SRCS + 2);

    typedef enum logic [2:0] {
        CMT_ALU = 3'd0,
        CMT_LD  = 3'd1,
        CMT_CSR = 3'd2,
        CMT_FPU = 3'd3,
        CMT_GPU = 3'd4
    } commit_src_e;

    localparam int NUM_CMT_SRCS = 5;

    typedef struct packed {
        logic [UUID_WIDTH-1:0]                uuid;
        logic [NW_BITS-1:0]                   wid;
        logic [NUM_THREADS-1:0]               tmask;
        logic [XLEN-1:0]                      pc;
        logic [NR_BITS-1:0]                   rd;
        logic [NUM_THREADS-1:0][XLEN-1:0]     data;
        logic                                 eop;
    } commit_data_t;

endpackage

// File: rtl/vx_commit_arb_if.sv
// Bundle of the commit-source lanes, store commit, writeback port and retire count.
//   slave  : the commit arbiter (consumes src_*/st_*, produces wb_*/cmt_*)
//   master : the surrounding core (execute units, register file, CSR unit)
interface vx_commit_arb_if;
    import vx_commit_arb_pkg::*;

    logic [NUM_SRCS-1:0]                              src_valid;
    logic [NUM_SRCS-1:0]                              src_ready;
    logic [NUM_SRCS-1:0][UUID_WIDTH-1:0]              src_uuid;
    logic [NUM_SRCS-1:0][NW_BITS-1:0]                 src_wid;
    logic [NUM_SRCS-1:0][NUM_THREADS-1:0]             src_tmask;
    logic [NUM_SRCS-1:0][XLEN-1:0]                    src_pc;
    logic [NUM_SRCS-1:0]                              src_wb;
    logic [NUM_SRCS-1:0][NR_BITS-1:0]                 src_rd;
    logic [NUM_SRCS-1:0][NUM_THREADS-1:0][XLEN-1:0]   src_data;
    logic [NUM_SRCS-1:0]                              src_eop;

    logic                                             st_valid;
    logic                                             st_ready;
    logic                                             st_eop;

    logic                                             wb_valid;
    logic                                             wb_ready;
    logic [UUID_WIDTH-1:0]                            wb_uuid;
    logic [NW_BITS-1:0]                               wb_wid;
    logic [NUM_THREADS-1:0]                           wb_tmask;
    logic [XLEN-1:0]                                  wb_pc;
    logic [NR_BITS-1:0]                               wb_rd;
    logic [NUM_THREADS-1:0][XLEN-1:0]                 wb_data;
    logic                                             wb_eop;

    logic                                             cmt_valid;
    logic [CNT_W-1:0]                                 cmt_count;

    modport slave (
        input  src_valid, src_uuid, src_wid, src_tmask, src_pc, src_wb, src_rd, src_data, src_eop,
        output src_ready,
        input  st_valid, st_eop,
        output st_ready,
        output wb_valid, wb_uuid, wb_wid, wb_tmask, wb_pc, wb_rd, wb_data, wb_eop,
        input  wb_ready,
        output cmt_valid, cmt_count
    );

    modport master (
        output src_valid, src_uuid, src_wid, src_tmask, src_pc, src_wb, src_rd, src_data, src_eop,
        input  src_ready,
        output st_valid, st_eop,
        input  st_ready,
        input  wb_valid, wb_uuid, wb_wid, wb_tmask, wb_pc, wb_rd, wb_data, wb_eop,
        output wb_ready,
        input  cmt_valid, cmt_count
    );

endinterface

// File: rtl/vx_commit_arb_rr_arbiter.sv
// Round-robin arbiter. Grants the first requester at or after the pointer,
// wrapping modulo NUM_REQS; the pointer advances past the winner on a grant.
//   clk, reset   : clock, synchronous active-high reset (pointer -> 0)
//   req          : request vector
//   enable       : a grant may be issued this cycle
//   grant_onehot : one-hot grant (zero when no grant)
//   grant_index  : binary index of the grant
//   grant_valid  : a grant was issued this cycle
module vx_rr_arbiter #(
    parameter  int NUM_REQS = 5,
    localparam int IDX_W    = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_REQS-1:0] req,
    input  logic                enable,
    output logic [NUM_REQS-1:0] grant_onehot,
    output logic [IDX_W-1:0]    grant_index,
    output logic                grant_valid
);

    logic [IDX_W-1:0] ptr;
    int               idx;

    always_comb begin
        grant_onehot = '0;
        grant_index  = '0;
        grant_valid  = 1'b0;
        idx          = 0;
        for (int i = 0; i < NUM_REQS; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_REQS) idx = idx - NUM_REQS;
            if (enable && !grant_valid && req[IDX_W'(idx)]) begin
                grant_valid                = 1'b1;
                grant_index                = IDX_W'(idx);
                grant_onehot[IDX_W'(idx)]  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (grant_valid) begin
            ptr <= (grant_index == IDX_W'(NUM_REQS - 1)) ? '0 : grant_index + IDX_W'(1);
        end
    end

endmodule

// File: rtl/vx_commit_arb.sv
// Commit/writeback stage: merges the per-unit commit streams into one register
// file writeback port through a single elastic output register (1-cycle latency),
// retires store commits, and reports the per-cycle retired-instruction count.
//   clk, reset : clock, synchronous active-high reset
//   bus        : source lanes, store commit, writeback port, retire count
module vx_commit_arb
    import vx_commit_arb_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    vx_commit_arb_if.slave bus
);

    localparam int IDX_W = (NUM_SRCS > 1) ? $clog2(NUM_SRCS) : 1;

    commit_data_t          src_pkt [NUM_SRCS];
    commit_data_t          wb_q;
    logic                  wb_valid_q;
    logic [NUM_SRCS-1:0]   wb_req;
    logic [NUM_SRCS-1:0]   grant_onehot;
    logic [IDX_W-1:0]      grant_index;
    logic                  grant_valid;
    logic                  slot_free;
    logic [NUM_SRCS-1:0]   fire;
    logic [CNT_W-1:0]      n_retired;

    always_comb begin
        for (int i = 0; i < NUM_SRCS; i++) begin
            src_pkt[i].uuid  = bus.src_uuid[i];
            src_pkt[i].wid   = bus.src_wid[i];
            src_pkt[i].tmask = bus.src_tmask[i];
            src_pkt[i].pc    = bus.src_pc[i];
            src_pkt[i].rd    = bus.src_rd[i];
            src_pkt[i].data  = bus.src_data[i];
            src_pkt[i].eop   = bus.src_eop[i];
        end
    end

    assign wb_req    = bus.src_valid & bus.src_wb;
    // The slot can take a new packet when empty or when it drains this cycle.
    assign slot_free = !wb_valid_q || bus.wb_ready;

    vx_rr_arbiter #(.NUM_REQS(NUM_SRCS)) rr_arb (
        .clk          (clk),
        .reset        (reset),
        .req          (wb_req),
        .enable       (slot_free && !reset),
        .grant_onehot (grant_onehot),
        .grant_index  (grant_index),
        .grant_valid  (grant_valid)
    );

    // Non-writeback commits need no slot, so they are always accepted.
    assign bus.src_ready = reset ? '0 : ((bus.src_valid & ~bus.src_wb) | grant_onehot);
    assign bus.st_ready  = !reset;
    assign fire          = bus.src_valid & bus.src_ready;

    always_comb begin
        n_retired = '0;
        for (int i = 0; i < NUM_SRCS; i++) begin
            n_retired = n_retired + CNT_W'(fire[i] & bus.src_eop[i]);
        end
        n_retired = n_retired + CNT_W'(bus.st_valid & bus.st_ready & bus.st_eop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_valid_q    <= 1'b0;
            wb_q          <= '0;
            bus.cmt_valid <= 1'b0;
            bus.cmt_count <= '0;
        end else begin
            if (grant_valid) begin
                wb_valid_q <= 1'b1;
                wb_q       <= src_pkt[grant_index];
            end else if (bus.wb_ready) begin
                wb_valid_q <= 1'b0;
            end
            bus.cmt_valid <= (n_retired != '0);
            bus.cmt_count <= n_retired;
        end
    end

    assign bus.wb_valid = wb_valid_q;
    assign bus.wb_uuid  = wb_q.uuid;
    assign bus.wb_wid   = wb_q.wid;
    assign bus.wb_tmask = wb_q.tmask;
    assign bus.wb_pc    = wb_q.pc;
    assign bus.wb_rd    = wb_q.rd;
    assign bus.wb_data  = wb_q.data;
    assign bus.wb_eop   = wb_q.eop;

endmodule

// File: tb/tb_vx_commit_arb.sv
module tb_vx_commit_arb;
    import vx_commit_arb_pkg::*;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    vx_commit_arb_if bus ();

    vx_commit_arb dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_src;
        bus.src_valid = '0;
        bus.src_wb    = '0;
        bus.src_eop   = '0;
        bus.st_valid  = 1'b0;
        bus.st_eop    = 1'b0;
    endtask

    task automatic set_src(input int i, input logic wb, input logic [NR_BITS-1:0] rd,
                           input logic [XLEN-1:0] d, input logic eop, input logic [NUM_THREADS-1:0] tm);
        bus.src_valid[i] = 1'b1;
        bus.src_wb[i]    = wb;
        bus.src_rd[i]    = rd;
        bus.src_data[i]  = {NUM_THREADS{d}};
        bus.src_eop[i]   = eop;
        bus.src_tmask[i] = tm;
        bus.src_uuid[i]  = UUID_WIDTH'(32'h100 + i);
        bus.src_wid[i]   = NW_BITS'(i);
        bus.src_pc[i]    = XLEN'(32'h1000 + 4 * i);
    endtask

    initial begin
        logic [2:0] gseq [4];
        n_vec = 0;
        n_err = 0;
        bus.src_valid = '0; bus.src_uuid = '0; bus.src_wid = '0; bus.src_tmask = '0;
        bus.src_pc = '0; bus.src_wb = '0; bus.src_rd = '0; bus.src_data = '0; bus.src_eop = '0;
        bus.st_valid = 1'b0; bus.st_eop = 1'b0; bus.wb_ready = 1'b0;
        reset = 1'b1;

        // 1: reset held with every source requesting
        for (int i = 0; i < NUM_SRCS; i++) set_src(i, 1'b1, NR_BITS'(i), 32'h0, 1'b1, 4'hf);
        bus.st_valid = 1'b1; bus.st_eop = 1'b1;
        repeat (3) begin
            tick;
            chk("rst_src_ready", 128'(bus.src_ready), 128'(5'b00000));
            chk("rst_st_ready",  128'(bus.st_ready), 128'(1'b0));
            chk("rst_wb_valid",  128'(bus.wb_valid), 128'(1'b0));
            chk("rst_cmt_valid", 128'(bus.cmt_valid), 128'(1'b0));
        end
        reset = 1'b0;
        clear_src;

        // 2: ALU only
        set_src(0, 1'b1, 6'd5, 32'h11111111, 1'b1, 4'hf);
        bus.wb_ready = 1'b1;
        #1;
        chk("alu_src_ready", 128'(bus.src_ready), 128'(5'b00001));
        tick;
        chk("alu_wb_valid", 128'(bus.wb_valid), 128'(1'b1));
        chk("alu_wb_rd",    128'(bus.wb_rd), 128'(6'd5));
        chk("alu_wb_data",  128'(bus.wb_data), {4{32'h11111111}});
        chk("alu_wb_uuid",  128'(bus.wb_uuid), 128'(44'h100));
        chk("alu_wb_pc",    128'(bus.wb_pc), 128'(32'h1000));
        chk("alu_wb_eop",   128'(bus.wb_eop), 128'(1'b1));
        chk("alu_cmt_count", 128'(bus.cmt_count), 128'(3'd1));
        chk("alu_cmt_valid", 128'(bus.cmt_valid), 128'(1'b1));

        // GPU alone from pointer 1 wraps the pointer back to 0
        clear_src;
        set_src(4, 1'b1, 6'd9, 32'h55555555, 1'b1, 4'hf);
        #1;
        chk("gpu_src_ready", 128'(bus.src_ready), 128'(5'b10000));
        tick;
        chk("gpu_wb_rd",  128'(bus.wb_rd), 128'(6'd9));
        chk("gpu_wb_wid", 128'(bus.wb_wid), 128'(2'd0));

        // 3: ALU, LD, CSR all requesting every cycle
        gseq[0] = 3'd0; gseq[1] = 3'd1; gseq[2] = 3'd2; gseq[3] = 3'd0;
        for (int k = 0; k < 4; k++) begin
            clear_src;
            set_src(0, 1'b1, 6'd1, 32'hA0, 1'b1, 4'hf);
            set_src(1, 1'b1, 6'd2, 32'hA1, 1'b1, 4'hf);
            set_src(2, 1'b1, 6'd3, 32'hA2, 1'b1, 4'hf);
            #1;
            chk("rr_src_ready", 128'(bus.src_ready), 128'(5'b00001 << gseq[k]));
            tick;
            chk("rr_wb_rd",     128'(bus.wb_rd), 128'(gseq[k] + 3'd1));
            chk("rr_wb_valid",  128'(bus.wb_valid), 128'(1'b1));
            chk("rr_cmt_count", 128'(bus.cmt_count), 128'(3'd1));
        end

        // 4: register file stalls with LD pending; ALU payload must hold
        clear_src;
        set_src(1, 1'b1, 6'd2, 32'h22222222, 1'b1, 4'hf);
        bus.wb_ready = 1'b0;
        repeat (4) begin
            #1;
            chk("stall_src_ready", 128'(bus.src_ready), 128'(5'b00000));
            tick;
            chk("stall_wb_valid", 128'(bus.wb_valid), 128'(1'b1));
            chk("stall_wb_rd",    128'(bus.wb_rd), 128'(6'd1));
            chk("stall_wb_data",  128'(bus.wb_data), {4{32'hA0}});
            chk("stall_cmt",      128'(bus.cmt_count), 128'(3'd0));
        end
        bus.wb_ready = 1'b1;
        #1;
        chk("release_src_ready", 128'(bus.src_ready), 128'(5'b00010));
        tick;
        chk("release_wb_rd",   128'(bus.wb_rd), 128'(6'd2));
        chk("release_wb_data", 128'(bus.wb_data), {4{32'h22222222}});
        chk("release_cmt",     128'(bus.cmt_count), 128'(3'd1));
        clear_src;
        tick;
        chk("drain_wb_valid", 128'(bus.wb_valid), 128'(1'b0));

        // 5: GPU non-wb, FPU wb, store in one cycle
        set_src(4, 1'b0, 6'd0, 32'h0, 1'b1, 4'hf);
        set_src(3, 1'b1, 6'd7, 32'h77777777, 1'b1, 4'hf);
        bus.st_valid = 1'b1; bus.st_eop = 1'b1;
        #1;
        chk("mix_src_ready", 128'(bus.src_ready), 128'(5'b11000));
        chk("mix_st_ready",  128'(bus.st_ready), 128'(1'b1));
        tick;
        chk("mix_cmt_count", 128'(bus.cmt_count), 128'(3'd3));
        chk("mix_cmt_valid", 128'(bus.cmt_valid), 128'(1'b1));
        chk("mix_wb_rd",     128'(bus.wb_rd), 128'(6'd7));
        set_src(4, 1'b0, 6'd0, 32'h0, 1'b0, 4'hf);
        #1;
        chk("mix2_src_ready", 128'(bus.src_ready), 128'(5'b11000));
        tick;
        chk("mix2_cmt_count", 128'(bus.cmt_count), 128'(3'd2));
        clear_src;
        tick;
        chk("idle_cmt_count", 128'(bus.cmt_count), 128'(3'd0));
        chk("idle_cmt_valid", 128'(bus.cmt_valid), 128'(1'b0));
        chk("idle_wb_valid",  128'(bus.wb_valid), 128'(1'b0));

        // 6: reset while the output is stalled; pointer must restart at 0
        set_src(0, 1'b1, 6'd12, 32'hDEADBEEF, 1'b1, 4'h0);
        bus.wb_ready = 1'b0;
        tick;
        chk("pre_rst_wb_valid", 128'(bus.wb_valid), 128'(1'b1));
        chk("zero_tmask",       128'(bus.wb_tmask), 128'(4'h0));
        clear_src;
        tick;
        chk("held_wb_valid", 128'(bus.wb_valid), 128'(1'b1));
        reset = 1'b1;
        tick;
        chk("midrst_wb_valid",  128'(bus.wb_valid), 128'(1'b0));
        chk("midrst_cmt_valid", 128'(bus.cmt_valid), 128'(1'b0));
        reset = 1'b0;
        set_src(0, 1'b1, 6'd13, 32'h13, 1'b1, 4'hf);
        set_src(2, 1'b1, 6'd14, 32'h14, 1'b1, 4'hf);
        bus.wb_ready = 1'b1;
        #1;
        chk("postrst_src_ready", 128'(bus.src_ready), 128'(5'b00001));
        tick;
        chk("postrst_wb_rd", 128'(bus.wb_rd), 128'(6'd13));
        clear_src;
        tick;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
